// File: rtl/folding_2_inv_if.sv
// rtl/folding_2_inv_if.sv - sample/result handshake bundle for the folded inverse filter
interface folding_2_inv_if #(
    parameter int n = 16
);
    logic         in_valid;
    logic         in_ready;
    logic [n-1:0] Yn;
    logic [n-1:0] a;
    logic [n-1:0] b;
    logic         out_valid;
    logic [n-1:0] Xn;

    modport master (
        output in_valid, Yn, a, b,
        input  in_ready, out_valid, Xn
    );

    modport slave (
        input  in_valid, Yn, a, b,
        output in_ready, out_valid, Xn
    );
endinterface

// File: rtl/folding_2_inv.sv
// rtl/folding_2_inv.sv - 2-folded inverse filter x[n] = y[n] - a*y[n-3] - b*y[n-5]; FOLD_INV_SAT_EN selects saturating arithmetic
module folding_2_inv #(
    parameter int n = 16
) (
    input  logic           clk,
    input  logic           rst,
    folding_2_inv_if.slave bus
);
    typedef enum logic {S_P0, S_P1} state_t;

    state_t       state;
    logic [n-1:0] h1, h2, h3, h4, h5;
    logic [n-1:0] ys, ra, rb;
    logic [n-1:0] xn_q;
    logic         ov_q;
    logic [n-1:0] mul_x, mul_y;
    logic [n-1:0] res;

    // Ready only in phase 0 and never while reset is asserted.
    assign bus.in_ready  = (state == S_P0) && !rst;
    assign bus.out_valid = ov_q;
    assign bus.Xn        = xn_q;

    // Single multiplier operand select: (a, h3) in phase 0, (rb, h5) in phase 1.
    // While idle in phase 0 the latched ra keeps the multiplier inputs quiet.
    always_comb begin
        mul_x = ra;
        mul_y = h3;
        if (state == S_P0) begin
            mul_x = bus.in_valid ? bus.a : ra;
            mul_y = h3;
        end else begin
            mul_x = rb;
            mul_y = h5;
        end
    end

`ifdef FOLD_INV_SAT_EN
    localparam int AW = 2 * n + 2;

    logic signed [2*n-1:0] prod;
    logic [AW-1:0]         prod_ext;
    logic [AW-1:0]         sub_lhs;
    logic [AW-1:0]         diff;
    logic [AW-1:0]         acc;

    assign prod     = $signed(mul_x) * $signed(mul_y);
    assign prod_ext = {{2{prod[2*n-1]}}, prod};
    assign sub_lhs  = (state == S_P0) ? {{(AW - n){bus.Yn[n-1]}}, bus.Yn} : acc;
    assign diff     = sub_lhs - prod_ext;

    // Clamp when the bits above the n-bit result are not all copies of its sign.
    always_comb begin
        res = diff[n-1:0];
        if (diff[AW-1:n-1] != {(AW - n + 1){diff[AW-1]}}) begin
            res = diff[AW-1] ? {1'b1, {(n - 1){1'b0}}} : {1'b0, {(n - 1){1'b1}}};
        end
    end
`else
    logic [n-1:0] prod_ext;
    logic [n-1:0] sub_lhs;
    logic [n-1:0] diff;
    logic [n-1:0] acc;

    // Low n bits of the product; everything wraps modulo 2^n.
    assign prod_ext = mul_x * mul_y;
    assign sub_lhs  = (state == S_P0) ? bus.Yn : acc;
    assign diff     = sub_lhs - prod_ext;
    assign res      = diff;
`endif

    // Two-phase sequencer: phase 0 takes the sample and first product, phase 1 finishes and shifts history.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_P0;
            h1    <= '0;
            h2    <= '0;
            h3    <= '0;
            h4    <= '0;
            h5    <= '0;
            ys    <= '0;
            ra    <= '0;
            rb    <= '0;
            acc   <= '0;
            xn_q  <= '0;
            ov_q  <= 1'b0;
        end else begin
            case (state)
                S_P0: begin
                    ov_q <= 1'b0;
                    if (bus.in_valid) begin
                        ys    <= bus.Yn;
                        ra    <= bus.a;
                        rb    <= bus.b;
                        acc   <= diff;
                        state <= S_P1;
                    end
                end
                S_P1: begin
                    xn_q  <= res;
                    ov_q  <= 1'b1;
                    h5    <= h4;
                    h4    <= h3;
                    h3    <= h2;
                    h2    <= h1;
                    h1    <= ys;
                    state <= S_P0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_folding_2_inv.sv
// tb/tb_folding_2_inv.sv - directed and round-trip bench for folding_2_inv
module tb_folding_2_inv;
    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    folding_2_inv_if #(.n(16)) bus ();

    folding_2_inv #(.n(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.in_valid = 1'b0;
        tick();
        rst = 1'b0;
        #1;
    endtask

    // Present one sample, follow it through both phases and check the result.
    // With junk set, in_valid stays high during phase 1 carrying garbage that must be ignored.
    task automatic send(input string tag, input logic [15:0] y, input logic [15:0] ca,
                        input logic [15:0] cb, input logic [15:0] exp, input bit junk);
        int waitc;
        waitc = 0;
        while (!bus.in_ready && waitc < 8) begin
            tick();
            waitc++;
        end
        check({tag, "_rdy"}, 16'(bus.in_ready), 16'd1);
        bus.in_valid = 1'b1;
        bus.Yn = y;
        bus.a  = ca;
        bus.b  = cb;
        tick();
        check({tag, "_p1_rdy"}, 16'(bus.in_ready), 16'd0);
        check({tag, "_p1_ov"}, 16'(bus.out_valid), 16'd0);
        bus.in_valid = junk;
        bus.Yn = 16'hDEAD;
        bus.a  = 16'h0BAD;
        bus.b  = 16'h0BAD;
        tick();
        check({tag, "_ov"}, 16'(bus.out_valid), 16'd1);
        check({tag, "_xn"}, bus.Xn, exp);
        bus.in_valid = 1'b0;
    endtask

    logic [15:0] imp_y [9] = '{16'd1, 16'd0, 16'd0, 16'd2, 16'd0, 16'd3, 16'd4, 16'd0, 16'd12};
    logic [15:0] imp_x [9] = '{16'd1, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
    logic [15:0] wr_y  [7] = '{16'h8000, 16'h0000, 16'h0000, 16'h7FFF, 16'h0000, 16'h0000, 16'h8000};
    logic [15:0] wr_x  [7] = '{16'h8000, 16'h0000, 16'h0000, 16'hFFFF, 16'h0000, 16'h0000, 16'h0001};
    logic [15:0] yh [1:5];
    logic [15:0] ca, cb, xv, yv;

    initial begin
        rst = 1'b1;
        bus.in_valid = 1'b1;
        bus.Yn = 16'h1234;
        bus.a  = 16'd2;
        bus.b  = 16'd3;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_ov", 16'(bus.out_valid), 16'd0);
            check("rst_xn", bus.Xn, 16'd0);
            check("rst_rdy", 16'(bus.in_ready), 16'd0);
        end
        rst = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        check("post_rst_rdy", 16'(bus.in_ready), 16'd1);

        // Impulse inversion, back-to-back; first result shows 16'h1234 was never taken.
        for (int i = 0; i < 9; i++) begin
            send("imp", imp_y[i], 16'd2, 16'd3, imp_x[i], 1'b0);
        end

        // in_valid held high with garbage during phase 1.
        send("stall0", 16'd9, 16'd2, 16'd3, 16'd1, 1'b1);
        send("stall1", 16'd20, 16'd2, 16'd3, 16'd11, 1'b1);

        // Idle gap must not disturb history.
        for (int i = 0; i < 5; i++) begin
            tick();
            check("idle_ov", 16'(bus.out_valid), 16'd0);
            check("idle_xn", bus.Xn, 16'd11);
        end
        send("post_idle0", 16'd40, 16'd2, 16'd3, 16'd4, 1'b0);
        send("post_idle1", 16'd5, 16'd2, 16'd3, 16'hFFF3, 1'b0);
        send("coef_chg", 16'd25, 16'd1, 16'd0, 16'd5, 1'b0);

        // Wrap-around arithmetic from a clean history.
        do_reset();
        for (int i = 0; i < 7; i++) begin
            send("wrap", wr_y[i], 16'd1, 16'd0, wr_x[i], 1'b0);
        end

        // Reset during phase 1 abandons the sample and clears history.
        bus.in_valid = 1'b1;
        bus.Yn = 16'h0055;
        bus.a  = 16'd5;
        bus.b  = 16'd5;
        tick();
        check("midrst_p1", 16'(bus.in_ready), 16'd0);
        rst = 1'b1;
        bus.in_valid = 1'b0;
        tick();
        check("midrst_ov", 16'(bus.out_valid), 16'd0);
        check("midrst_xn", bus.Xn, 16'd0);
        rst = 1'b0;
        tick();
        check("midrst_ov2", 16'(bus.out_valid), 16'd0);
        send("midrst_next", 16'd7, 16'd5, 16'd5, 16'd7, 1'b0);

        // Round trip through a forward IIR model.
        do_reset();
        for (int i = 1; i <= 5; i++) yh[i] = 16'd0;
        ca = 16'($urandom);
        cb = 16'($urandom);
        for (int i = 0; i < 200; i++) begin
            xv = 16'($urandom);
            yv = xv + ca * yh[3] + cb * yh[5];
            send("rt", yv, ca, cb, xv, bit'(i % 2));
            yh[5] = yh[4];
            yh[4] = yh[3];
            yh[3] = yh[2];
            yh[2] = yh[1];
            yh[1] = yv;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
